// File: rtl/fetch_buffer.sv
// Instruction fetch stage: issues sequential word reads to a fixed-latency memory and
// queues returned {instr, pc} pairs in a small FIFO that decode drains one per cycle.
module fetch_buffer #(
    parameter int unsigned     WIDTH    = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             o_req,
    output logic [WIDTH-1:0] o_addr,
    input  logic [WIDTH-1:0] i_rdata,
    input  logic             i_redirect,
    input  logic [WIDTH-1:0] i_redirect_pc,
    output logic [WIDTH-1:0] o_instr,
    output logic [WIDTH-1:0] o_pc,
    output logic             o_imask,
    input  logic             i_en
);

    localparam int unsigned    AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]  PtrOne   = 1;
    localparam logic [AW:0]    CntOne   = 1;
    localparam logic [AW:0]    CntDepth = DEPTH[AW:0];
    localparam logic [WIDTH-1:0] PcStep = 4;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic             inflight_q, inflight_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [AW:0]      credit_sum;
    logic [WIDTH-1:0] instr_q [DEPTH];
    logic [WIDTH-1:0] ipc_q   [DEPTH];
    logic             push, pop;

    // Outstanding read counts against FIFO space so a returning word always has a slot.
    assign credit_sum = count_q + {{AW{1'b0}}, inflight_q};
    assign o_req      = !i_redirect && (credit_sum < CntDepth);
    assign o_addr     = pc_q;
    assign o_imask    = (count_q != '0);
    assign o_instr    = instr_q[rd_ptr_q];
    assign o_pc       = ipc_q[rd_ptr_q];

    assign push = inflight_q && !i_redirect;
    assign pop  = o_imask && i_en && !i_redirect;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        if (i_redirect) begin
            pc_d     = i_redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (o_req) begin
                pc_d          = pc_q + PcStep;
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrOne;
            end
            if (push && !pop) begin
                count_d = count_q + CntOne;
            end else if (pop && !push) begin
                count_d = count_q - CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                ipc_q[i]   <= '0;
            end
        end else if (push) begin
            instr_q[wr_ptr_q] <= i_rdata;
            ipc_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

endmodule
